serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: WIDTH, 8, operand and sum width in bits (legal range 2..32).
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to add X and Y; sampled only in IDLE.
REQ-006 X  input  WIDTH  addend A, sampled on the accepting edge.
REQ-007 Y  input  WIDTH  addend B, sampled on the accepting edge.
REQ-008 sum  output  WIDTH  registered result X+Y mod 2^WIDTH.
REQ-009 cout  output  1  registered carry out of the MSB.
REQ-010 busy  output  1  high while in RUN or DONE.
REQ-011 done  output  1  one-cycle pulse; sum and cout are valid in this cycle.

Function
REQ-012 States SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 IDLE->RUN on an edge with start=1, which latches X and Y into internal shift registers, clears the carry flop and clears the bit counter.
REQ-014 IDLE SHALL hold state when start=0; start SHALL be ignored in RUN and DONE.
REQ-015 Each RUN edge SHALL process one bit, LSB first: s = a^b^c, c' = (a&b)|(c&(a^b)), built from two half-adder stages plus an OR gate.
REQ-016 Each RUN edge SHALL shift s into the result register, update the carry flop and increment the counter.
REQ-017 RUN->DONE on the edge that processes bit WIDTH-1; that same edge SHALL load sum from the result register and cout from the final carry.
REQ-018 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-019 done SHALL be 1 only in DONE.
REQ-020 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-021 sum and cout SHALL hold their last result until the next DONE entry.
REQ-022 Partial results SHALL never appear on sum or cout.
REQ-023 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-024 Changes on X and Y after acceptance SHALL NOT affect the result in progress.

Reset
REQ-025 rst=1 SHALL force state=IDLE, sum=0, cout=0, busy=0, done=0, carry=0, counter=0, and clear the operand registers, immediately and independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the block SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN SHALL gate one feature.
REQ-028 With SERIAL_ADDER_OVF_EN defined, output ovf (1 bit) SHALL exist, equal to the carry into the MSB XOR cout (two's-complement overflow).
REQ-029 ovf SHALL be registered with sum and cout, follow the same hold rules, and reset to 0.
REQ-030 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-031 Reset, then X=0x00, Y=0x00, start=1 for 1 cycle -> done high exactly 9 cycles after the accepting edge; sum=0x00, cout=0.
REQ-032 X=0xFF, Y=0x01 -> sum=0x00, cout=1; X=0xA5, Y=0x5A -> sum=0xFF, cout=0; busy high from the accepting edge through the done cycle.
REQ-033 Start X=0x0F, Y=0x01, then pulse start with X=0xFF, Y=0xFF in the 3rd RUN cycle -> second start ignored; result sum=0x10, cout=0; exactly one done.
REQ-034 Start X=0x80, Y=0x80, assert rst in the 4th RUN cycle -> outputs 0 immediately, no done; after release, X=0x03, Y=0x04 -> sum=0x07.
REQ-035 start held high for 30 cycles with X=0x01, Y=0x01 -> done every 10 cycles, sum=0x02 each time.
REQ-036 With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; 0xFF+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: LSB-first, one bit per clock, IDLE/RUN/DONE FSM.
// Ports: clk, rst (async, active-high), start, X, Y -> sum, cout, busy, done
//        (+ ovf when SERIAL_ADDER_OVF_EN is defined).
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow flag (carry into MSB xor carry out of MSB).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // a_q doubles as the result register: each RUN edge shifts one operand
    // bit out of the bottom and the matching sum bit in at the top, so after
    // WIDTH shifts it holds the complete sum.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;

    logic             last_bit;
    logic             p, g1, g2;
    logic             s_bit, c_next;
    logic [WIDTH-1:0] a_next;

    assign last_bit = (cnt_q == LAST);

    // Two half-adder stages plus an OR for the carry.
    assign p      = a_q[0] ^ b_q[0];
    assign g1     = a_q[0] & b_q[0];
    assign s_bit  = p ^ c_q;
    assign g2     = p & c_q;
    assign c_next = g1 | g2;
    assign a_next = {s_bit, a_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath: operands, carry, bit counter and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= X;
                        b_q   <= Y;
                        c_q   <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_next;
                    b_q   <= b_q >> 1;
                    c_q   <= c_next;
                    cnt_q <= cnt_q + CW'(1);
                    // Result only becomes visible once the final bit is in.
                    if (last_bit) begin
                        sum  <= a_next;
                        cout <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_q here is the carry into the MSB.
                        ovf  <= c_q ^ c_next;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
